// File: rtl/midi_event_encoder.sv
// midi_event_encoder
// Turns note-on / note-off requests into a paced serial MIDI byte stream
// (status, data1, data2). Requests go through a small FIFO so that bursts of
// button events are not lost while earlier messages are still being sent.
// Each byte appears for one cycle on midi_data/midi_valid. Consecutive bytes
// of a message are separated by BYTE_GAP idle cycles.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   note_on_req    request a note-on  (note_num, velocity, channel)
//   note_off_req   request a note-off (note_num, channel); wins if both high
//   note_num       MIDI note number 0..127
//   velocity       note-on velocity (ignored for note-off)
//   channel        MIDI channel 0..15
//   req_ready      FIFO not full; requests are accepted only while high
//   req_dropped    one-cycle pulse after a request that was refused
//   midi_data      current MIDI byte; holds its value between strobes
//   midi_valid     one-cycle strobe per byte
//   busy           FIFO non-empty or a message is in flight
module midi_event_encoder #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned BYTE_GAP       = 16,
  parameter int unsigned RUNNING_STATUS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_on_req,
  input  logic       note_off_req,
  input  logic [6:0] note_num,
  input  logic [6:0] velocity,
  input  logic [3:0] channel,
  output logic       req_ready,
  output logic       req_dropped,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic       busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GAP_W = $clog2(BYTE_GAP + 1);

  localparam logic [3:0] NOTE_ON_NIB  = 4'h9;
  localparam logic [3:0] NOTE_OFF_NIB = 4'h8;
  localparam logic [7:0] OFF_VELOCITY = 8'h40;

  // One queued request
  typedef struct packed {
    logic       is_on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STATUS,
    S_DATA1,
    S_DATA2,
    S_GAP
  } state_t;

  // Request FIFO storage and bookkeeping
  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Message sequencing
  state_t           state_q;
  state_t           state_d;
  state_t           ret_q;       // byte state to resume after the gap
  state_t           ret_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  req_t             msg_q;
  logic [7:0]       status_q;
  logic [7:0]       status_d;
  logic [7:0]       last_status_q;
  logic [7:0]       last_status_d;

  // Registered outputs
  logic             ready_q;
  logic             dropped_q;
  logic [7:0]       data_q;
  logic [7:0]       data_d;
  logic             valid_q;
  logic             valid_d;
  logic             busy_q;

  logic             req_any;
  logic             push;
  logic             pop;
  req_t             new_req;

  // Request capture; note-off has priority when both requests are high
  always_comb begin
    req_any       = note_on_req | note_off_req;
    push          = req_any & ready_q;
    pop           = (state_q == S_IDLE) && (count_q != '0);
    new_req.is_on = note_on_req & ~note_off_req;
    new_req.ch    = channel;
    new_req.note  = note_num;
    new_req.vel   = velocity;
  end

  // Occupancy update; a simultaneous push and pop leaves count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO payload storage (no reset needed; guarded by pointers/count)
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr_q] <= new_req;
    end
  end

  // Next-state and byte generation
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    gap_d         = gap_q;
    status_d      = status_q;
    last_status_d = last_status_q;
    valid_d       = 1'b0;
    data_d        = data_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        status_d = msg_q.is_on ? {NOTE_ON_NIB, msg_q.ch} : {NOTE_OFF_NIB, msg_q.ch};
        // Running status skips the status byte when it repeats the last one sent
        if ((RUNNING_STATUS != 0) && (status_d == last_status_q)) begin
          state_d = S_DATA1;
        end else begin
          state_d = S_STATUS;
        end
      end

      S_STATUS: begin
        valid_d       = 1'b1;
        data_d        = status_q;
        last_status_d = status_q;
        gap_d         = GAP_W'(BYTE_GAP);
        ret_d         = S_DATA1;
        state_d       = S_GAP;
      end

      S_DATA1: begin
        valid_d = 1'b1;
        data_d  = {1'b0, msg_q.note};
        gap_d   = GAP_W'(BYTE_GAP);
        ret_d   = S_DATA2;
        state_d = S_GAP;
      end

      S_DATA2: begin
        valid_d = 1'b1;
        data_d  = msg_q.is_on ? {1'b0, msg_q.vel} : OFF_VELOCITY;
        gap_d   = GAP_W'(BYTE_GAP);
        ret_d   = S_IDLE;
        state_d = S_GAP;
      end

      S_GAP: begin
        // Gap spans BYTE_GAP cycles starting with the strobe cycle itself,
        // so strobes land BYTE_GAP+1 cycles apart
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = ret_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, FIFO pointers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ret_q         <= S_IDLE;
      gap_q         <= '0;
      msg_q         <= '0;
      status_q      <= 8'h00;
      last_status_q <= 8'h00;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      dropped_q     <= 1'b0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      gap_q         <= gap_d;
      status_q      <= status_d;
      last_status_q <= last_status_d;
      count_q       <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        msg_q    <= fifo_mem[rd_ptr_q];
      end
      ready_q   <= (count_d != CNT_W'(FIFO_DEPTH));
      dropped_q <= req_any & ~ready_q;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= (count_d != '0) || (state_d != S_IDLE);
    end
  end

  assign req_ready   = ready_q;
  assign req_dropped = dropped_q;
  assign midi_data   = data_q;
  assign midi_valid  = valid_q;
  assign busy        = busy_q;

endmodule
